data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_pkg.sv | 23 ++
 rtl/data_mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data memory arbiter: FSM state encoding, owner
// identifiers for the two requesters and the default access latency.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   // Arbiter sequencing: wait for a request, hold the memory, hand back data
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

   // Owner / last-grant encoding
   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   // Cycles the data memory is occupied per access
   localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
// Shares one single-port DataMemory between the CPU memory stage and a
// secondary DMA/loader port. Simultaneous requests are resolved round-robin.
// Each access occupies the memory for LATENCY cycles (BUSY), followed by one
// DONE cycle in which the owner sees its registered read data.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   cpu_req    : CPU access request, held until completion
//   cpu_we     : CPU write enable
//   cpu_addr   : CPU address
//   cpu_wdata  : CPU store data
//   cpu_rdata  : registered read data returned to the CPU
//   cpu_stall  : freezes the CPU pipeline while its access is pending
//   dma_req    : DMA access request, held until dma_done
//   dma_we     : DMA write enable
//   dma_addr   : DMA address
//   dma_wdata  : DMA write data
//   dma_gnt    : DMA owns the memory (BUSY and DONE)
//   dma_done   : one-cycle pulse when the DMA access completes
//   dma_rdata  : registered read data returned to the DMA
//   mem_we     : DataMemory write enable (first BUSY cycle only)
//   mem_addr   : DataMemory address
//   mem_wdata  : DataMemory write data
//   mem_rdata  : DataMemory read data
// -----------------------------------------------------------------------------
module data_mem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY,
   parameter int AW      = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [AW-1:0] cpu_wdata,
   output logic [AW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [AW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_done,
   output logic [AW-1:0] dma_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [AW-1:0] mem_wdata,
   input  logic [AW-1:0] mem_rdata
);

   // BUSY counts down from LATENCY-1 to 0, so LATENCY cycles in total
   localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

   arb_state_t    r_state;
   logic          r_owner;
   logic          r_lastGrant;
   logic [3:0]    r_count;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] r_wdata;
   logic [AW-1:0] r_cpuRdata;
   logic [AW-1:0] r_dmaRdata;
   logic          r_memWe;
   logic          r_dmaGnt;
   logic          r_dmaDone;

   logic          w_winner;
   logic          w_selWe;
   logic [AW-1:0] w_selAddr;
   logic [AW-1:0] w_selWdata;

   // Pick the requester to serve next: a lone request wins outright, a tie
   // goes to whoever was not granted last time
   assign w_winner = (cpu_req && dma_req) ? ((r_lastGrant == OWN_CPU) ? OWN_DMA : OWN_CPU)
                                          : (dma_req ? OWN_DMA : OWN_CPU);

   // Route the winner's access so it can be latched at the grant edge
   assign w_selWe    = (w_winner == OWN_DMA) ? dma_we    : cpu_we;
   assign w_selAddr  = (w_winner == OWN_DMA) ? dma_addr  : cpu_addr;
   assign w_selWdata = (w_winner == OWN_DMA) ? dma_wdata : cpu_wdata;

   // Arbitration FSM with registered memory/handshake outputs. The async
   // reset also aborts an access in flight, dropping mem_we immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_owner     <= OWN_CPU;
         r_lastGrant <= OWN_DMA;
         r_count     <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpuRdata  <= '0;
         r_dmaRdata  <= '0;
         r_memWe     <= 1'b0;
         r_dmaGnt    <= 1'b0;
         r_dmaDone   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cpu_req || dma_req) begin
                  r_state     <= ST_BUSY;
                  r_owner     <= w_winner;
                  r_lastGrant <= w_winner;
                  r_count     <= COUNT_LOAD;
                  r_we        <= w_selWe;
                  r_addr      <= w_selAddr;
                  r_wdata     <= w_selWdata;
                  r_memWe     <= w_selWe;
                  r_dmaGnt    <= (w_winner == OWN_DMA);
               end
            end
            ST_BUSY: begin
               r_memWe <= 1'b0;
               if (r_count == 4'd0) begin
                  // Capture on writes too, so the owner always sees a fresh value
                  if (r_owner == OWN_DMA) begin
                     r_dmaRdata <= mem_rdata;
                  end else begin
                     r_cpuRdata <= mem_rdata;
                  end
                  r_dmaDone <= (r_owner == OWN_DMA);
                  r_state   <= ST_DONE;
               end else begin
                  r_count <= r_count - 4'd1;
               end
            end
            ST_DONE: begin
               r_state   <= ST_IDLE;
               r_dmaGnt  <= 1'b0;
               r_dmaDone <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // The CPU is released exactly in the DONE cycle of its own access
   assign cpu_stall = cpu_req & ~((r_state == ST_DONE) && (r_owner == OWN_CPU));

   assign cpu_rdata = r_cpuRdata;
   assign dma_rdata = r_dmaRdata;
   assign dma_gnt   = r_dmaGnt;
   assign dma_done  = r_dmaDone;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Drives directed accesses into two arbiter instances (LATENCY 2 and 1), each
// in front of a small behavioural memory. Expected completions are queued at
// issue time and a monitor pops and compares them as the DUT finishes.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;
   import dmem_arb_pkg::*;

   typedef struct {
      logic        isDma;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        reset;

   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dma_req, dma_we;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic        dma_gnt, dma_done;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        cpu_req1;
   logic [31:0] cpu_addr1, cpu_rdata1;
   logic        cpu_stall1;
   logic [31:0] dma_rdata1;
   logic        dma_gnt1, dma_done1;
   logic        mem_we1;
   logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

   logic [31:0] memArray [0:255];
   bit   [255:0] memWritten;

   exp_t sbq [$];
   int   vecCount  = 0;
   int   missCount = 0;
   int   doneCount = 0;

   data_mem_arbiter #(.LATENCY(2), .AW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .dma_req   (dma_req),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_gnt   (dma_gnt),
      .dma_done  (dma_done),
      .dma_rdata (dma_rdata),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   data_mem_arbiter #(.LATENCY(1), .AW(32)) dut1 (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req1),
      .cpu_we    (1'b0),
      .cpu_addr  (cpu_addr1),
      .cpu_wdata (32'h0),
      .cpu_rdata (cpu_rdata1),
      .cpu_stall (cpu_stall1),
      .dma_req   (1'b0),
      .dma_we    (1'b0),
      .dma_addr  (32'h0),
      .dma_wdata (32'h0),
      .dma_gnt   (dma_gnt1),
      .dma_done  (dma_done1),
      .dma_rdata (dma_rdata1),
      .mem_we    (mem_we1),
      .mem_addr  (mem_addr1),
      .mem_wdata (mem_wdata1),
      .mem_rdata (mem_rdata1)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Power-on memory contents: one known word at 0x40, a pattern elsewhere
   function automatic logic [31:0] initPattern(input logic [7:0] idx);
      return (idx == 8'd16) ? 32'h1234_5678 : {24'hA5A5A5, idx};
   endfunction

   // Behavioural single-port memory behind the LATENCY=2 arbiter
   always @(posedge clk) begin
      if (mem_we) begin
         memArray[mem_addr[9:2]]   <= mem_wdata;
         memWritten[mem_addr[9:2]] <= 1'b1;
      end
   end

   assign mem_rdata  = memWritten[mem_addr[9:2]] ? memArray[mem_addr[9:2]]
                                                 : initPattern(mem_addr[9:2]);
   // Read-only memory behind the LATENCY=1 arbiter
   assign mem_rdata1 = initPattern(mem_addr1[9:2]);

   // Single comparison point: counts every check and reports misses
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Scoreboard monitor: a completion is the CPU's release cycle or dma_done
   always @(negedge clk) begin
      if (reset) begin
         if ((cpu_req && !cpu_stall) || dma_done) begin
            doneCount++;
            if (sbq.size() == 0) begin
               checkOutput("unexpected completion", {31'b0, dma_done}, 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               checkOutput("completion owner", {31'b0, dma_done}, {31'b0, e.isDma});
               checkOutput("completion rdata", dma_done ? dma_rdata : cpu_rdata, e.data);
            end
         end
      end
   end

   // One CPU access on the LATENCY=2 arbiter; reports stall length and mem_we activity
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expData, output int stalls,
                                output int weCnt, output logic [31:0] weAddr);
      exp_t e;
      @(posedge clk); #1;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      e.isDma = 1'b0;
      e.data  = expData;
      sbq.push_back(e);
      stalls = 0;
      weCnt  = 0;
      weAddr = '0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (mem_we) begin
            weCnt++;
            weAddr = mem_addr;
         end
         if (!cpu_stall) break;
         stalls++;
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
   endtask

   // One CPU read on the LATENCY=1 arbiter; req is left high by a following call
   task automatic readLat1(input logic [31:0] addr, output int stalls,
                           output logic [31:0] rdata, output time doneAt);
      cpu_req1  = 1'b1;
      cpu_addr1 = addr;
      stalls    = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (!cpu_stall1) break;
         stalls++;
      end
      rdata  = cpu_rdata1;
      doneAt = $time;
      @(posedge clk); #1;
      cpu_req1 = 1'b0;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Global bound so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int          stalls, weCnt, gntCnt, doneCnt, stallCnt, base;
      logic [31:0] weAddr, rd1, rd2;
      time         t1, t2;
      exp_t        e;

      reset     = 1'b0;
      cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dma_req   = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      cpu_req1  = 1'b0; cpu_addr1 = '0;

      // Reset values, and cpu_stall following cpu_req while in reset
      #12;
      checkOutput("reset mem_we",    {31'b0, mem_we},   32'h0);
      checkOutput("reset dma_gnt",   {31'b0, dma_gnt},  32'h0);
      checkOutput("reset dma_done",  {31'b0, dma_done}, 32'h0);
      checkOutput("reset cpu_rdata", cpu_rdata,         32'h0);
      checkOutput("reset dma_rdata", dma_rdata,         32'h0);
      checkOutput("reset mem_addr",  mem_addr,          32'h0);
      cpu_req = 1'b1;
      #1;
      checkOutput("reset cpu_stall follows req", {31'b0, cpu_stall}, 32'h1);
      cpu_req = 1'b0;
      #1;
      checkOutput("reset cpu_stall idle", {31'b0, cpu_stall}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // CPU read of 0x40: stall over IDLE + 2 BUSY cycles, released in DONE
      applyStimulus(1'b0, 32'h40, 32'h0, 32'h1234_5678, stalls, weCnt, weAddr);
      checkOutput("read 0x40 stall cycles", stalls, 32'd3);
      checkOutput("read 0x40 mem_we pulses", weCnt, 32'd0);

      // CPU write then read-back of 0x80
      applyStimulus(1'b1, 32'h80, 32'hDEAD_BEEF, 32'hDEAD_BEEF, stalls, weCnt, weAddr);
      checkOutput("write 0x80 stall cycles", stalls, 32'd3);
      checkOutput("write 0x80 mem_we pulses", weCnt, 32'd1);
      checkOutput("write 0x80 mem_addr", weAddr, 32'h80);
      applyStimulus(1'b0, 32'h80, 32'h0, 32'hDEAD_BEEF, stalls, weCnt, weAddr);
      checkOutput("readback 0x80 stall cycles", stalls, 32'd3);

      // DMA write with the CPU idle: 3 cycles of grant, one done pulse
      @(posedge clk); #1;
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h100; dma_wdata = 32'h0000_00FF;
      e.isDma = 1'b1; e.data = 32'h0000_00FF;
      sbq.push_back(e);
      gntCnt = 0; doneCnt = 0; stallCnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         gntCnt   += int'(dma_gnt);
         doneCnt  += int'(dma_done);
         stallCnt += int'(cpu_stall);
         if (dma_done) begin
            @(posedge clk); #1;
            dma_req = 1'b0; dma_we = 1'b0;
         end
      end
      dma_req = 1'b0; dma_we = 1'b0;
      checkOutput("dma write gnt cycles", gntCnt, 32'd3);
      checkOutput("dma write done pulses", doneCnt, 32'd1);
      checkOutput("dma write cpu_stall", stallCnt, 32'd0);

      // Three back-to-back ties after reset: CPU, DMA, CPU
      pulseReset();
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h100;
      e.isDma = 1'b0; e.data = 32'h1234_5678; sbq.push_back(e);
      e.isDma = 1'b1; e.data = 32'h0000_00FF; sbq.push_back(e);
      e.isDma = 1'b0; e.data = 32'h1234_5678; sbq.push_back(e);
      base = doneCount;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); #1;
         if (doneCount - base >= 3) break;
      end
      checkOutput("tie completions", doneCount - base, 32'd3);
      @(posedge clk); #1;
      cpu_req = 1'b0; dma_req = 1'b0;

      // Reset in the first BUSY cycle of a write aborts it immediately
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h55AA_55AA;
      @(posedge clk); #2;
      checkOutput("abort mem_we first BUSY", {31'b0, mem_we}, 32'h1);
      reset = 1'b0;
      #1;
      checkOutput("abort mem_we async drop", {31'b0, mem_we}, 32'h0);
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(1'b0, 32'h80, 32'h0, 32'hDEAD_BEEF, stalls, weCnt, weAddr);
      checkOutput("post-abort read stall cycles", stalls, 32'd3);
      checkOutput("post-abort read mem_we pulses", weCnt, 32'd0);

      // LATENCY=1: back-to-back reads, each done at t+2, one IDLE cycle apart
      @(posedge clk); #1;
      readLat1(32'h40, stalls, rd1, t1);
      checkOutput("lat1 read1 stall cycles", stalls, 32'd2);
      checkOutput("lat1 read1 rdata", rd1, 32'h1234_5678);
      readLat1(32'h44, stalls, rd2, t2);
      checkOutput("lat1 read2 stall cycles", stalls, 32'd2);
      checkOutput("lat1 read2 rdata", rd2, 32'hA5A5_A511);
      checkOutput("lat1 done spacing ns", 32'(t2 - t1), 32'd30);

      repeat (3) @(posedge clk);
      checkOutput("scoreboard drained", sbq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
